commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Downstream observer of the pipelined RISC-V core's retire-side trace outputs: register write-back (reg_write_sig/reg_num/reg_data) and data-memory port (wr/rd/addr/wr_data/rd_data).
- Captures each event into a tagged record in a FIFO.
- Drains records over a valid/ready stream to a trace sink (UART bridge or bench scoreboard).
- Counts events lost to backpressure.

Parameters:
- DATA_W, 32, data width of reg_data/wr_data/rd_data and record payload.
- DEPTH, 16, FIFO entries; power of two, >= 4.
- OVF_W, 16, width of saturating overflow counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- reg_write_sig  input  1  core register write strobe
- reg_num  input  5  destination register index
- reg_data  input  DATA_W  write-back value
- wr  input  1  data-memory write strobe
- rd  input  1  data-memory read strobe
- addr  input  9  data-memory address
- wr_data  input  DATA_W  store data
- rd_data  input  DATA_W  load data
- out_valid  output  1  head record available
- out_ready  input  1  sink accepts head record
- out_type  output  2  record type: 01 REG_WR, 10 MEM_WR, 11 MEM_RD
- out_idx  output  9  REG_WR: {4'b0, reg_num}; MEM_*: addr
- out_data  output  DATA_W  reg_data / wr_data / rd_data
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky; set on any dropped event
- overflow_cnt  output  OVF_W  dropped events, saturating at all-ones

Behaviour:
- Reset: reset sampled low at a rising edge clears pointers. Outputs then read count=0, out_valid=0, out_type/out_idx/out_data=0, overflow=0, overflow_cnt=0. Inputs sampled in a reset cycle are discarded. Mid-stream reset discards all stored records.
- Event qualification, per cycle:
  - reg_ev = reg_write_sig && reg_num != 0.
  - mem_ev = wr || rd.
  - If wr and rd are both high, a single MEM_WR record is produced; rd is ignored.
- Record order within a cycle: reg_ev first, then mem_ev. Across cycles: strict arrival order.
- Free space: free = DEPTH - count, taken before this cycle's pop. A pop does not free space for the same cycle's pushes.
- Push rules:
  - free >= 2: push all qualified events (0, 1 or 2).
  - free == 1 with 2 events: push the REG_WR record; drop the MEM record.
  - free == 0: drop all qualified events.
- Each dropped event sets overflow and adds 1 to overflow_cnt, saturating. Two drops in one cycle add 2, saturating.
- Output is first-word-fall-through:
  - out_valid = (count != 0).
  - out_type/out_idx/out_data present the head record combinationally from storage.
  - All out_* fields are 0 when empty.
- Pop happens when out_valid && out_ready. out_ready while empty has no effect.
- Latency: an event sampled at edge N is visible at the output after edge N when the FIFO was empty.
- count(next) = count + pushes - pop. Simultaneous push and pop are always legal. Pointers wrap modulo DEPTH.
- overflow and overflow_cnt are cleared only by reset.

Optional Feature:
- Macro: COMMIT_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, incrementing every non-reset cycle and wrapping.
  - Each record stores the counter value of its capture cycle; both records of one cycle share the same value.
  - Adds output out_timestamp (32), which is 0 when empty.
- Undefined: no counter, no out_timestamp port, no timestamp storage.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> out_valid=0, count=0, overflow_cnt=0. Then reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF for one cycle -> next cycle out_valid=1, out_type=01, out_idx=5, out_data=0xDEADBEEF.
- x0 filter and rd/wr conflict: reg_num=0 with reg_write_sig=1, plus wr=1, rd=1, addr=0x1A4, wr_data=0x11 -> exactly one record, MEM_WR, idx=0x1A4, data=0x11; count=1.
- Dual event ordering: reg_num=3/data=7 together with rd=1, addr=8, rd_data=9 in the same cycle -> count=2; pops yield REG_WR(3,7), then MEM_RD(8,9).
- Fill and overflow, DEPTH=16, out_ready=0:
  - 8 cycles of dual events -> count=16, overflow=0.
  - One more dual event -> both dropped; overflow=1, overflow_cnt=2.
- free==1 split: with count=15, out_ready=1 and a dual event in the same cycle -> REG record pushed, MEM dropped, one pop; count=15, overflow_cnt=1.
- Reset mid-drain: with count=6 and out_ready toggling, assert reset for one cycle -> count=0, out_valid=0, overflow_cnt=0. With COMMIT_TRACE_TIMESTAMP_EN, the first post-reset record captured 3 cycles after reset release shows out_timestamp=2.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Retire-side trace capture: register write-backs and data-memory accesses are tagged into a
// FIFO and drained over a first-word-fall-through valid/ready stream; dropped events are counted.
// Optional: define COMMIT_TRACE_TIMESTAMP_EN to stamp each record with a free-running cycle count.
module commit_trace_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned OVF_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reg_write_sig,
  input  logic [4:0]              reg_num,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [8:0]              addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_type,
  output logic [8:0]              out_idx,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [OVF_W-1:0]        overflow_cnt
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]             out_timestamp
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned OW1 = OVF_W + 1;

  localparam logic [1:0] TypeRegWr = 2'b01;
  localparam logic [1:0] TypeMemWr = 2'b10;
  localparam logic [1:0] TypeMemRd = 2'b11;

  logic [1:0]        type_mem [DEPTH];
  logic [8:0]        idx_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nxt;
  logic [CW-1:0]     count_q, count_d, free;
  logic              overflow_q, overflow_d;
  logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [OW1-1:0]    ovf_sum;

  logic              reg_ev, mem_ev, pop, empty;
  logic              push0, push1;
  logic [1:0]        n_push, n_drop;

  logic [1:0]        mem_type, rec0_type;
  logic [8:0]        mem_idx, rec0_idx;
  logic [DATA_W-1:0] mem_data, rec0_data;

  // Event qualification; a simultaneous wr+rd is reported as a store only.
  assign reg_ev   = reg_write_sig && (reg_num != 5'd0);
  assign mem_ev   = wr || rd;
  assign mem_type = wr ? TypeMemWr : TypeMemRd;
  assign mem_idx  = addr;
  assign mem_data = wr ? wr_data : rd_data;

  // Slot 0 holds the first event of the cycle (register write wins), slot 1 only ever the memory one.
  assign rec0_type = reg_ev ? TypeRegWr : mem_type;
  assign rec0_idx  = reg_ev ? {4'b0000, reg_num} : mem_idx;
  assign rec0_data = reg_ev ? reg_data : mem_data;

  assign empty      = (count_q == '0);
  assign pop        = !empty && out_ready;
  assign free       = CW'(DEPTH) - count_q;
  assign wr_ptr_nxt = wr_ptr_q + AW'(1);

  always_comb begin
    push0  = 1'b0;
    push1  = 1'b0;
    n_drop = 2'd0;
    // Space is judged before this cycle's pop; a pop never makes room for a same-cycle push.
    if (free >= CW'(2)) begin
      push0 = reg_ev || mem_ev;
      push1 = reg_ev && mem_ev;
    end else if (free == CW'(1)) begin
      push0  = reg_ev || mem_ev;
      n_drop = {1'b0, reg_ev && mem_ev};
    end else begin
      n_drop = {1'b0, reg_ev} + {1'b0, mem_ev};
    end
  end

  assign n_push = {1'b0, push0} + {1'b0, push1};

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(n_push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(n_push) - CW'(pop);
    overflow_d = overflow_q || (n_drop != 2'd0);
    ovf_sum    = {1'b0, ovf_cnt_q} + OW1'(n_drop);
    ovf_cnt_d  = ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Record storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && push0) begin
      type_mem[wr_ptr_q] <= rec0_type;
      idx_mem[wr_ptr_q]  <= rec0_idx;
      data_mem[wr_ptr_q] <= rec0_data;
    end
    if (reset && push1) begin
      type_mem[wr_ptr_nxt] <= mem_type;
      idx_mem[wr_ptr_nxt]  <= mem_idx;
      data_mem[wr_ptr_nxt] <= mem_data;
    end
  end

  assign out_valid    = !empty;
  assign out_type     = empty ? 2'b00 : type_mem[rd_ptr_q];
  assign out_idx      = empty ? 9'd0 : idx_mem[rd_ptr_q];
  assign out_data     = empty ? '0 : data_mem[rd_ptr_q];
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign overflow_cnt = ovf_cnt_q;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  // Both records of one cycle share that cycle's stamp.
  always_ff @(posedge clk) begin
    if (reset && push0) begin
      ts_mem[wr_ptr_q] <= ts_q;
    end
    if (reset && push1) begin
      ts_mem[wr_ptr_nxt] <= ts_q;
    end
  end

  assign out_timestamp = empty ? 32'd0 : ts_mem[rd_ptr_q];
`endif

endmodule
